// File: rtl/sysid_arbiter.sv
// Round-robin two-master read arbiter in front of the combinational sysid slave.
// Define SYSID_ARB_BOOTCHECK_EN to add the post-reset ID/timestamp check sequencer.
module sysid_arbiter #(
    parameter logic [31:0] EXPECT_ID = 32'd0,
    parameter logic [31:0] EXPECT_TS = 32'd1412490851
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_address,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,
    output logic        s_address,
    input  logic [31:0] s_readdata,
    output logic        check_done,
    output logic        check_fail
);

    typedef enum logic [1:0] {
        CHK_ID = 2'd0,
        CHK_TS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;  // index of the master granted most recently
    logic   grant0;
    logic   grant1;

`ifdef SYSID_ARB_BOOTCHECK_EN
    state_t next_state;
    logic   id_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CHK_ID;
            id_bad     <= 1'b0;
            check_fail <= 1'b0;
        end else begin
            state <= next_state;
            if (state == CHK_ID)
                id_bad <= (s_readdata != EXPECT_ID);
            if (state == CHK_TS)
                check_fail <= id_bad | (s_readdata != EXPECT_TS);
        end
    end

    // NOTE: defaults first so every path assigns next_state and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            CHK_ID:  next_state = CHK_TS;
            CHK_TS:  next_state = DONE;
            default: next_state = DONE;
        endcase
    end
`else
    assign state      = DONE;
    assign check_fail = 1'b0;
`endif

    assign check_done = (state == DONE);

    // Gating with reset_n keeps both masters stalled while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n && state == DONE) begin
            grant0 = m0_read && (!m1_read || last_grant);
            grant1 = m1_read && (!m0_read || !last_grant);
        end
    end

    assign m0_waitrequest = !grant0;
    assign m1_waitrequest = !grant1;

    always_comb begin
        s_address = 1'b0;
        case (state)
            CHK_ID:  s_address = 1'b0;
            CHK_TS:  s_address = 1'b1;
            default: s_address = grant0 ? m0_address : (grant1 ? m1_address : 1'b0);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant       <= 1'b1;
            m0_readdata      <= 32'd0;
            m1_readdata      <= 32'd0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            m0_readdatavalid <= grant0;
            m1_readdatavalid <= grant1;
            if (grant0) begin
                m0_readdata <= s_readdata;
                last_grant  <= 1'b0;
            end
            if (grant1) begin
                m1_readdata <= s_readdata;
                last_grant  <= 1'b1;
            end
        end
    end

endmodule
